// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester count and the rotating-priority winner search.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arbState_e;

  // First set request bit, searching upward from ptr with 2-bit wrap.
  function automatic logic [1:0] pickWinner(input logic [N_REQ-1:0] req,
                                            input logic [1:0]       ptr);
    logic [1:0] idx;
    logic [1:0] winner;
    logic       found;
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

  function automatic logic [N_REQ-1:0] oneHot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4_sel.sv
// Plain combinational 4:1 single-bit mux; shared with the existing datapath.
module mux4_sel
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] x,
  input  logic             c1,
  input  logic             c0,
  output logic             y
);

  always_comb begin
    y = x[{c1, c0}];
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 mux and releases
// the owner on done, request withdrawal or a hold-time limit.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic [N_REQ-1:0] x,
  output logic [N_REQ-1:0] grant,
  output logic             c1,
  output logic             c0,
  output logic             busy,
  output logic             timeout,
  output logic             y
);

  arbState_e        state_q;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             timeout_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] holdCnt_q;

  logic [1:0]       winner;
  logic [1:0]       ptr_d;
  logic [CNT_W-1:0] holdCnt_d;
  logic             ownerReq;
  logic             holdLimit;
  logic             releaseNow;
  logic             timeoutHit;
  logic             muxBit;

  always_comb begin
    winner     = pickWinner(req, ptr_q);
    ownerReq   = req[sel_q];
    holdLimit  = (holdCnt_q == CNT_W'(MAX_HOLD - 1));
    releaseNow = done || !ownerReq || holdLimit;
    // A timeout is only flagged when the counter is the sole release cause.
    timeoutHit = holdLimit && !done && ownerReq;
    ptr_d      = sel_q + 2'd1;
    holdCnt_d  = holdCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'b00;
      holdCnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q   <= OWN;
            grant_q   <= oneHot(winner);
            sel_q     <= winner;
            busy_q    <= 1'b1;
            holdCnt_q <= '0;
          end
        end
        OWN: begin
          if (releaseNow) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            timeout_q <= timeoutHit;
          end else begin
            holdCnt_q <= holdCnt_d;
          end
        end
      endcase
    end
  end

  mux4_sel uMux (
    .x  (x),
    .c1 (sel_q[1]),
    .c0 (sel_q[0]),
    .y  (muxBit)
  );

  assign grant   = grant_q;
  assign c1      = sel_q[1];
  assign c0      = sel_q[0];
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign y       = busy_q & muxBit;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] x;
  logic [3:0] grant;
  logic       c1;
  logic       c0;
  logic       busy;
  logic       timeout;
  logic       y;

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .x       (x),
    .grant   (grant),
    .c1      (c1),
    .c0      (c0),
    .busy    (busy),
    .timeout (timeout),
    .y       (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  logic [3:0] expGrant [9];
  logic [1:0] expSel   [5];
  int         busyCycles;
  int         toPulses;
  int         toAtRelease;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    x     = 4'b0000;
    #12;
    checkOutput("rst_grant", grant, 4'b0000);
    checkOutput("rst_sel", {c1, c0}, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_timeout", timeout, 1'b0);
    checkOutput("rst_y", y, 1'b0);
    rst_n = 1'b1;

    // Single requester 2 and mux routing.
    req = 4'b0100;
    step();
    checkOutput("t1_grant", grant, 4'b0100);
    checkOutput("t1_sel", {c1, c0}, 2'b10);
    checkOutput("t1_busy", busy, 1'b1);
    x = 4'b0100; #1;
    checkOutput("t1_y_x2hi", y, 1'b1);
    x = 4'b0101; #1;
    checkOutput("t1_y_x0tog", y, 1'b1);
    x = 4'b0001; #1;
    checkOutput("t1_y_x2lo", y, 1'b0);
    x = 4'b1011; #1;
    checkOutput("t1_y_others", y, 1'b0);
    req = 4'b0000;
    step();
    checkOutput("t1_rel_busy", busy, 1'b0);
    checkOutput("t1_rel_sel", {c1, c0}, 2'b10);
    checkOutput("t1_rel_y", y, 1'b0);

    // Fairness with all four requesting and done after each grant.
    doReset();
    expGrant = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    expSel   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      checkOutput($sformatf("t2_grant%0d", i), grant, expGrant[i]);
      checkOutput($sformatf("t2_busy%0d", i), busy, |expGrant[i]);
      if (i % 2 == 0)
        checkOutput($sformatf("t2_sel%0d", i), {c1, c0}, expSel[i/2]);
      done = (i % 2 == 0) && (i < 8);
    end
    done = 1'b0;

    // Hold timeout with a single persistent requester.
    doReset();
    req = 4'b0001;
    step();
    checkOutput("t3_grant", grant, 4'b0001);
    busyCycles  = 1;
    toPulses    = 0;
    toAtRelease = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (timeout) toPulses++;
      if (!busy) begin
        toAtRelease = timeout;
        break;
      end
      busyCycles++;
    end
    checkOutput("t3_busy_cycles", busyCycles, 8);
    checkOutput("t3_to_at_release", toAtRelease, 1);
    step();
    checkOutput("t3_regrant", grant, 4'b0001);
    checkOutput("t3_to_cleared", timeout, 1'b0);
    checkOutput("t3_to_pulses", toPulses, 1);

    // Withdrawal by owner 3, pointer wraps to 0; done in IDLE is ignored.
    doReset();
    req = 4'b1000;
    step();
    checkOutput("t4_grant3", grant, 4'b1000);
    req = 4'b0000;
    step();
    checkOutput("t4_rel_busy", busy, 1'b0);
    checkOutput("t4_rel_timeout", timeout, 1'b0);
    req  = 4'b1001;
    done = 1'b1;
    step();
    done = 1'b0;
    checkOutput("t4_wrap_grant", grant, 4'b0001);
    checkOutput("t4_wrap_sel", {c1, c0}, 2'b00);

    // Non-owner requests ignored; done coinciding with the hold limit.
    doReset();
    req = 4'b0010;
    step();
    checkOutput("t5_grant", grant, 4'b0010);
    req = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput($sformatf("t5_hold%0d", i), grant, 4'b0010);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checkOutput("t5_rel_busy", busy, 1'b0);
    checkOutput("t5_rel_timeout", timeout, 1'b0);
    step();
    checkOutput("t5_next_grant", grant, 4'b1000);

    // Asynchronous reset in the middle of a grant.
    doReset();
    req = 4'b0100;
    x   = 4'b0100;
    step();
    checkOutput("t6_grant", grant, 4'b0100);
    checkOutput("t6_y", y, 1'b1);
    for (int i = 0; i < 3; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_grant", grant, 4'b0000);
    checkOutput("t6_async_busy", busy, 1'b0);
    checkOutput("t6_async_y", y, 1'b0);
    checkOutput("t6_async_sel", {c1, c0}, 2'b00);
    rst_n = 1'b1;
    step();
    checkOutput("t6_regrant", grant, 4'b0100);
    checkOutput("t6_regrant_busy", busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
